// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage ALU with registered result, built-in decode of
// aluop/opcode/funct, and an iterative shift-add multiplier that writes HI/LO.
// Optional restoring divider (div/divu), enabled by defining ALU_EXEC_DIV_EN.
module alu_exec_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } op_t;

`ifdef ALU_EXEC_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;
`endif

    // Map the aluop/opcode/funct combination onto one internal operation.
    function automatic op_t decode_op(input logic [1:0] sel,
                                      input logic [5:0] opc,
                                      input logic [5:0] fn);
        op_t op;
        op = OP_ILL;
        case (sel)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (opc)
                    6'b001000: op = OP_ADD;
                    6'b001100: op = OP_AND;
                    6'b001101: op = OP_OR;
                    6'b001110: op = OP_XOR;
                    6'b001010: op = OP_SLT;
                    6'b001011: op = OP_SLTU;
                    default:   op = OP_ILL;
                endcase
            end
            default: begin
                case (fn)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    6'b011000: op = OP_MULT;
                    6'b011001: op = OP_MULTU;
`ifdef ALU_EXEC_DIV_EN
                    6'b011010: op = OP_DIV;
                    6'b011011: op = OP_DIVU;
`endif
                    default:   op = OP_ILL;
                endcase
            end
        endcase
        return op;
    endfunction

    // Single-cycle datapath; anything not handled here (illegal) yields zero.
    function automatic logic [WIDTH-1:0] alu_eval(input op_t op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] hv,
                                                  input logic [WIDTH-1:0] lv);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: r = hv;
            OP_MFLO: r = lv;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Magnitude of a two's-complement value; the most negative value maps to
    // itself, which reads correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] neg1w(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;

    op_t                op;
    logic               accept;
    logic               is_mul;
    logic               is_signed;
    logic               last_step;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;

    assign op         = decode_op(aluop, opcode, funct);
    assign accept     = in_valid & in_ready;
    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign single_res = alu_eval(op, src_a, src_b, hi, lo);
    assign last_step  = (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_EXEC_DIV_EN
    logic               is_div;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    // Restoring divider: acc = {partial remainder, dividend/quotient bits}.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand};
    assign div_next  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    // With a zero divisor the remainder ends as |a|; restoring its sign gives a back.
    assign quo_fix   = div_zero ? '1
                     : (neg_q ? neg1w(div_next[WIDTH-1:0]) : div_next[WIDTH-1:0]);
    assign rem_fix   = neg_r ? neg1w(div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];
`else
    assign is_signed = (op == OP_MULT);
`endif

    assign op_a = is_signed ? mag(src_a) : src_a;
    assign op_b = is_signed ? mag(src_b) : src_b;

    // Shift-add multiplier: acc = {running partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign prod_fix = neg_q ? neg2w(mul_next) : mul_next;

    // Iterative datapath: load operands on accept, then one step per busy cycle.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            if (accept) begin
`ifdef ALU_EXEC_DIV_EN
                mcand <= is_div ? op_b : op_a;
                acc   <= {{WIDTH{1'b0}}, (is_div ? op_a : op_b)};
`else
                mcand <= op_a;
                acc   <= {{WIDTH{1'b0}}, op_b};
`endif
            end
        end else if (state == S_MUL) begin
            acc <= mul_next;
`ifdef ALU_EXEC_DIV_EN
        end else begin
            acc <= div_next;
`endif
        end
    end

    // Control FSM and architectural result/HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            neg_q     <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state    <= S_MUL;
                            in_ready <= 1'b0;
                            cnt      <= '0;
                            neg_q    <= (op == OP_MULT) & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef ALU_EXEC_DIV_EN
                        end else if (is_div) begin
                            state    <= S_DIV;
                            in_ready <= 1'b0;
                            cnt      <= '0;
                            neg_q    <= (op == OP_DIV) & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            neg_r    <= (op == OP_DIV) & src_a[WIDTH-1];
                            div_zero <= (src_b == '0);
`endif
                        end else begin
                            out_valid <= 1'b1;
                            illegal   <= (op == OP_ILL);
                            result    <= single_res;
                            zero      <= (single_res == '0);
                        end
                    end
                end
                S_MUL: begin
                    if (last_step) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        illegal   <= 1'b0;
                        hi        <= prod_fix[2*WIDTH-1:WIDTH];
                        lo        <= prod_fix[WIDTH-1:0];
                        result    <= prod_fix[WIDTH-1:0];
                        zero      <= (prod_fix[WIDTH-1:0] == '0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef ALU_EXEC_DIV_EN
                S_DIV: begin
                    if (last_step) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        illegal   <= 1'b0;
                        hi        <= rem_fix;
                        lo        <= quo_fix;
                        result    <= quo_fix;
                        zero      <= (quo_fix == '0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
